// File: rtl/rvga_membus_io.sv
// Shared request/response memory bus used between the rvga core, the arbiter and memory.
// A requester holds read/write/addr/wdata until the single-cycle resp pulse.
interface rvga_membus_io;
  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] rvga_word;

  logic     read;
  logic     write;
  rvga_word addr;
  rvga_word wdata;
  logic     resp;
  rvga_word rdata;

  modport master (output read, output write, output addr, output wdata,
                  input resp, input rdata);
  modport slave  (input read, input write, input addr, input wdata,
                  output resp, output rdata);
endinterface

// File: rtl/rvga_membus_arbiter.sv
// Round-robin 2:1 arbiter merging instruction-fetch and data buses onto one memory bus.
// The grant is registered; forwarding and the response path are combinational.
module rvga_membus_arbiter (
  input  logic         clk_i,
  input  logic         rst_i,
  rvga_membus_io.slave  imem,
  rvga_membus_io.slave  dmem,
  rvga_membus_io.master mem
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // last_q: 1'b0 = I served last, 1'b1 = D served last
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   req_i, req_d;

  assign req_i = imem.read | imem.write;
  assign req_d = dmem.read | dmem.write;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= LAST_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    mem.read   = 1'b0;
    mem.write  = 1'b0;
    mem.addr   = '0;
    mem.wdata  = '0;
    imem.resp  = 1'b0;
    imem.rdata = '0;
    dmem.resp  = 1'b0;
    dmem.rdata = '0;

    unique case (state_q)
      IDLE: begin
        // Stray mem.resp in IDLE is dropped by never routing it anywhere
        if (req_i && req_d) begin
          state_d = (last_q == LAST_D) ? SERVE_I : SERVE_D;
        end else if (req_i) begin
          state_d = SERVE_I;
        end else if (req_d) begin
          state_d = SERVE_D;
        end
      end

      SERVE_I: begin
        mem.read  = imem.read;
        mem.write = imem.write;
        mem.addr  = imem.addr;
        mem.wdata = imem.wdata;
        if (!req_i) begin
          state_d = IDLE;
        end else if (mem.resp) begin
          imem.resp  = 1'b1;
          imem.rdata = mem.rdata;
          last_d     = LAST_I;
          state_d    = req_d ? SERVE_D : IDLE;
        end
      end

      SERVE_D: begin
        mem.read  = dmem.read;
        mem.write = dmem.write;
        mem.addr  = dmem.addr;
        mem.wdata = dmem.wdata;
        if (!req_d) begin
          state_d = IDLE;
        end else if (mem.resp) begin
          dmem.resp  = 1'b1;
          dmem.rdata = mem.rdata;
          last_d     = LAST_D;
          state_d    = req_i ? SERVE_I : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
